// File: rtl/systolic_result_drain_pkg.sv
// Shared accelerator definitions: array geometry defaults, drain FSM states and
// the requantization shift clamp.
package systolic_result_drain_pkg;

  localparam int SIZE_DEF        = 16;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int ACCUM_WIDTH_DEF = 32;
  localparam int SHIFT_W         = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } drain_state_e;

  // Shifts at or beyond the accumulator width collapse to the widest legal shift.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s,
                                                     input int unsigned    aw);
    if (32'(s) >= aw) return SHIFT_W'(aw - 1);
    return s;
  endfunction

endpackage

// File: rtl/systolic_result_drain_requant_sat.sv
// One requantization lane: round-half-up arithmetic right shift of an accumulator
// value followed by saturation to the signed output width. Purely combinational.
module requant_sat
  import systolic_result_drain_pkg::*;
#(
  parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic signed [ACCUM_WIDTH-1:0] x_i,
  input  logic        [SHIFT_W-1:0]     shift_i,
  output logic signed [DATA_WIDTH-1:0]  y_o
);

  localparam logic signed [ACCUM_WIDTH:0] MAX_V =
    {{(ACCUM_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH:0] MIN_V =
    {{(ACCUM_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACCUM_WIDTH:0] x_ext;
  logic signed [ACCUM_WIDTH:0] rnd;
  logic signed [ACCUM_WIDTH:0] sum;
  logic signed [ACCUM_WIDTH:0] shd;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  always_comb begin
    x_ext = {x_i[ACCUM_WIDTH-1], x_i};
    rnd   = '0;
    if (shift_i != '0) rnd = (ACCUM_WIDTH+1)'(1) << (shift_i - SHIFT_W'(1));
    sum   = x_ext + rnd;
    shd   = sum >>> shift_i;
    if (shd > MAX_V)      y_o = MAX_V[DATA_WIDTH-1:0];
    else if (shd < MIN_V) y_o = MIN_V[DATA_WIDTH-1:0];
    else                  y_o = shd[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array accumulators on capture, clears the array, then
// streams the snapshot out one requantized row per ready/valid beat.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int SIZE        = SIZE_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          capture,
  input  logic        [SHIFT_W-1:0]                     shift_amt,
  input  logic signed [SIZE-1:0][SIZE-1:0][ACCUM_WIDTH-1:0] result_matrix,
  output logic                                          accum_reset_out,
  output logic                                          busy,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [SIZE-1:0][DATA_WIDTH-1:0]        out_data,
  output logic        [$clog2(SIZE)-1:0]                out_row,
  output logic                                          out_last,
  output logic                                          done
);

  localparam int                ROW_W    = $clog2(SIZE);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(SIZE - 1);
  localparam logic [ROW_W-1:0]  PENULT   = ROW_W'(SIZE - 2);

  drain_state_e                                      state_q;
  logic        [ROW_W-1:0]                           row_q;
  logic        [SHIFT_W-1:0]                         shift_q;
  logic                                              valid_q;
  logic                                              last_q;
  logic                                              done_q;
  logic                                              busy_q;
  logic                                              accr_q;
  logic signed [SIZE-1:0][SIZE-1:0][ACCUM_WIDTH-1:0] buf_q;

  logic                                              accept;
  logic                                              xfer;
  logic signed [SIZE-1:0][ACCUM_WIDTH-1:0]           row_sel;
  logic signed [SIZE-1:0][DATA_WIDTH-1:0]            lane_y;

  assign accept = (state_q == IDLE) && capture;
  assign xfer   = valid_q && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      accr_q  <= 1'b0;
    end else begin
      accr_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= STREAM;
            row_q   <= '0;
            shift_q <= clamp_shift(shift_amt, ACCUM_WIDTH);
            valid_q <= 1'b1;
            last_q  <= (SIZE == 1);
            busy_q  <= 1'b1;
            accr_q  <= 1'b1;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (row_q == LAST_ROW) begin
              state_q <= DONE;
              row_q   <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q  <= row_q + 1'b1;
              last_q <= (row_q == PENULT);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot storage has no reset; it is only observed while a stream is live.
  always_ff @(posedge clk) begin
    if (accept) buf_q <= result_matrix;
  end

  assign row_sel = buf_q[row_q];

  for (genvar c = 0; c < SIZE; c++) begin : g_lane
    requant_sat #(
      .ACCUM_WIDTH (ACCUM_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH)
    ) u_rq (
      .x_i     (row_sel[c]),
      .shift_i (shift_q),
      .y_o     (lane_y[c])
    );
  end

  assign out_data        = valid_q ? lane_y : '0;
  assign out_valid       = valid_q;
  assign out_row         = row_q;
  assign out_last        = last_q;
  assign done            = done_q;
  assign busy            = busy_q;
  assign accum_reset_out = accr_q;

endmodule
